audio_pwm_sink: RTL and testbench
=================================

AUDIO_PWM_SINK -- requirements
Module: audio_pwm_sink

Interface
REQ-001 Parameter PWM_BITS, default 8, PWM resolution; one PWM period is 2^PWM_BITS clock cycles.
REQ-002 Parameter FIFO_DEPTH, default 4, sample buffer depth in entries (power of two, >=2).
REQ-003 CLK  input  1  system clock; all state changes on its rising edge.
REQ-004 RST_N  input  1  reset; asynchronous assertion, active-low.
REQ-005 en  input  1  playback enable.
REQ-006 s_data  input  16  audio sample, signed two's complement.
REQ-007 s_valid  input  1  s_data is valid this cycle.
REQ-008 s_ready  output  1  sink can accept a sample this cycle.
REQ-009 level  output  clog2(FIFO_DEPTH)+1  number of buffered samples.
REQ-010 pwm_out  output  1  registered PWM audio output.
REQ-011 underrun  output  1  one-cycle pulse when a period starts with the FIFO empty.

Function
REQ-012 The block SHALL accept a sample on any cycle with s_valid=1 and s_ready=1.
REQ-013 s_ready SHALL equal (level != FIFO_DEPTH), combinationally from registered level.
REQ-014 The FIFO SHALL be first-in first-out, with no bypass path; a sample written in cycle N can be popped no earlier than cycle N+1.
REQ-015 On a push and a pop in the same cycle, level SHALL be unchanged and both operations SHALL take effect.
REQ-016 A PWM counter cnt (PWM_BITS wide) and a duty register (PWM_BITS wide) SHALL be maintained.
REQ-017 Duty conversion SHALL be {~s[15], s[14:16-PWM_BITS]}, i.e. the signed sample's top PWM_BITS bits with the MSB inverted (offset binary).
REQ-018 The state machine SHALL have two states, IDLE and RUN.
REQ-019 In IDLE, cnt SHALL be held at 2^PWM_BITS-1, pwm_out SHALL be 0, and no pop SHALL occur.
REQ-020 IDLE->RUN SHALL occur when en=1 and level>=2 (prefill).
REQ-021 RUN->IDLE SHALL occur on the first cycle en=0; that transition SHALL take priority over a period-end load in the same cycle.
REQ-022 In RUN, cnt SHALL increment by 1 each cycle and wrap from 2^PWM_BITS-1 to 0.
REQ-023 In RUN with cnt=2^PWM_BITS-1 and level>0, the head SHALL be popped and duty loaded with its converted value, effective the next cycle.
REQ-024 In RUN with cnt=2^PWM_BITS-1 and level=0, duty SHALL hold its previous value, and underrun SHALL be 1 for exactly that one cycle.
REQ-025 In RUN, pwm_out SHALL be registered as (cnt < duty), using current-cycle values (one-cycle output latency).
REQ-026 duty=0 SHALL give pwm_out constantly 0; duty=2^PWM_BITS-1 SHALL give 2^PWM_BITS-1 high cycles per period.
REQ-027 The FIFO contents and level SHALL be retained across RUN->IDLE; no flush.

Reset
REQ-028 While RST_N=0, the block SHALL be in IDLE with level=0, FIFO pointers=0, cnt=2^PWM_BITS-1, duty=0, pwm_out=0, underrun=0 and s_ready=1.
REQ-029 Reset assertion mid-period SHALL take effect immediately without waiting for CLK, discarding buffered samples.
REQ-030 The first push after release SHALL be accepted on the first rising edge with RST_N=1.

Verification
REQ-031 Reset: RST_N=0 -> s_ready=1, level=0, pwm_out=0, underrun=0.
REQ-032 Playback: with en=1, push 0x9FFF then 0x1FFF -> the first period has duty 0x1F (31 high cycles of 256), the second has duty 0x9F (159 high of 256).
REQ-033 Full: en=0 and 5 consecutive pushes -> level=4 and s_ready=0 after the 4th; the 5th is not accepted; FIFO order is preserved on playback.
REQ-034 Underrun: en=1 with only 2 samples pushed -> the 3rd period-end pulses underrun for 1 cycle, and duty holds 0x9F.
REQ-035 Disable: en dropped at cnt=100 -> the next cycle is IDLE with pwm_out=0 and level unchanged; on re-enable, playback resumes from the next buffered sample.
REQ-036 Async reset: RST_N pulsed low between clock edges during RUN -> outputs reach reset values before the next edge, and level=0.

Source files
------------

// File: rtl/audio_pwm_sink.sv
// rtl/audio_pwm_sink.sv - buffered audio sample sink driving a PWM output
module audio_pwm_sink #(
  parameter int PWM_BITS   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          en,
  input  logic [15:0]                   s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          pwm_out,
  output logic                          underrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;
  localparam logic [PWM_BITS-1:0] MSB_FLIP = {1'b1, {(PWM_BITS-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [PWM_BITS-1:0]   cnt_q, cnt_d;
  logic [PWM_BITS-1:0]   duty_q, duty_d;
  logic                  pwm_q, pwm_d;
  logic [LW-1:0]         level_q, level_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [15:0]           mem_q [FIFO_DEPTH];
  logic [15:0]           mem_d [FIFO_DEPTH];

  logic                  push;
  logic                  pop;
  logic                  underrun_c;
  logic [15:0]           head;
  logic [PWM_BITS-1:0]   head_duty;

  // Ready only looks at the registered level, so a full FIFO never takes a word even if a pop happens this cycle.
  assign s_ready   = (level_q != LW'(FIFO_DEPTH));
  assign push      = s_valid && s_ready;
  assign head      = mem_q[rd_ptr_q];
  // Offset-binary conversion: the sample's top bits with the sign bit inverted.
  assign head_duty = head[15 -: PWM_BITS] ^ MSB_FLIP;

  assign level    = level_q;
  assign pwm_out  = pwm_q;
  assign underrun = underrun_c;

  // Playback FSM: PWM counter, duty reload at period end, underrun detect and registered PWM compare.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    duty_d     = duty_q;
    pwm_d      = 1'b0;
    pop        = 1'b0;
    underrun_c = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = CNT_MAX;
        if (en && (level_q >= LW'(2))) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!en) begin
          // Disable wins over a period-end load in the same cycle.
          state_d = IDLE;
          cnt_d   = CNT_MAX;
        end else begin
          cnt_d = cnt_q + PWM_BITS'(1);
          pwm_d = (cnt_q < duty_q);
          if (cnt_q == CNT_MAX) begin
            if (level_q != '0) begin
              pop    = 1'b1;
              duty_d = head_duty;
            end else begin
              underrun_c = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_MAX;
      end
    endcase
  end

  // FIFO bookkeeping: write at wr_ptr, read at rd_ptr, level tracks push/pop (both cancel).
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = s_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // State registers; reset discards any buffered samples immediately.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      cnt_q    <= CNT_MAX;
      duty_q   <= '0;
      pwm_q    <= 1'b0;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      pwm_q    <= pwm_d;
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_audio_pwm_sink.sv
// tb/tb_audio_pwm_sink.sv - randomized and directed bench for audio_pwm_sink
module tb_audio_pwm_sink;

  localparam int FD   = 4;
  localparam int MAXC = 255;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        en;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [2:0]  level;
  logic        pwm_out;
  logic        underrun;

  always #5 CLK = ~CLK;

  audio_pwm_sink #(.PWM_BITS(8), .FIFO_DEPTH(FD)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .en       (en),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .level    (level),
    .pwm_out  (pwm_out),
    .underrun (underrun)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: sample queue, playing flag, position in the period, current duty.
  logic [15:0] q[$];
  bit          m_run;
  int          m_phase;
  int          m_duty;
  bit          m_pwm;
  bit          obs_pwm;
  bit          obs_und;

  function automatic int conv(logic [15:0] s);
    return int'($signed(s[15:8])) + 128;
  endfunction

  task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_run   = 1'b0;
    m_phase = MAXC;
    m_duty  = 0;
    m_pwm   = 1'b0;
  endtask

  task automatic tick();
    bit acc;
    bit nxt_pwm;
    bit und;
    @(negedge CLK);
    obs_pwm = pwm_out;
    obs_und = underrun;
    und = m_run && en && (m_phase == MAXC) && (q.size() == 0);
    check_eq("s_ready", 32'(s_ready), 32'(q.size() != FD));
    check_eq("level", 32'(level), 32'(q.size()));
    check_eq("pwm_out", 32'(pwm_out), 32'(m_pwm));
    check_eq("underrun", 32'(underrun), 32'(und));
    acc     = s_valid && (q.size() != FD);
    nxt_pwm = m_run && en && (m_phase < m_duty);
    if (m_run) begin
      if (!en) begin
        m_run   = 1'b0;
        m_phase = MAXC;
      end else if (m_phase == MAXC) begin
        if (q.size() > 0) m_duty = conv(q.pop_front());
        m_phase = 0;
      end else begin
        m_phase++;
      end
    end else if (en && q.size() >= 2) begin
      m_run = 1'b1;
    end
    if (acc) q.push_back(s_data);
    m_pwm = nxt_pwm;
    @(posedge CLK);
    #1;
  endtask

  task automatic push(logic [15:0] d);
    s_valid = 1'b1;
    s_data  = d;
    tick();
    s_valid = 1'b0;
  endtask

  // Asserts reset between edges, checks outputs before the next edge, releases away from an edge.
  task automatic do_reset();
    en      = 1'b0;
    s_valid = 1'b0;
    #2;
    RST_N = 1'b0;
    model_reset();
    #1;
    check_eq("rst_ready", 32'(s_ready), 32'd1);
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_pwm", 32'(pwm_out), 32'd0);
    check_eq("rst_underrun", 32'(underrun), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_phase(int ph, string tag);
    int n = 0;
    while (!(m_run && m_phase == ph) && n < 2000) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(m_run && m_phase == ph), 32'd1);
  endtask

  task automatic window(output int hi, output int un);
    hi = 0;
    un = 0;
    repeat (256) begin
      tick();
      hi += int'(obs_pwm);
      un += int'(obs_und);
    end
  endtask

  int hi;
  int un;
  int exp_d [5] = '{0, 64, 128, 192, 255};
  logic [15:0] full_v [5] = '{16'h8000, 16'hC000, 16'h0000, 16'h4000, 16'h7FFF};

  initial begin
    RST_N   = 1'b0;
    en      = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    model_reset();
    #3;
    check_eq("init_ready", 32'(s_ready), 32'd1);
    check_eq("init_level", 32'(level), 32'd0);
    check_eq("init_pwm", 32'(pwm_out), 32'd0);
    check_eq("init_underrun", 32'(underrun), 32'd0);
    repeat (2) tick();
    do_reset();

    // Playback of two samples, then underrun with duty held.
    push(16'h9FFF);
    push(16'h1FFF);
    en = 1'b1;
    wait_phase(0, "play_start");
    window(hi, un);
    check_eq("play_p1_high", 32'(hi), 32'd31);
    check_eq("play_p1_und", 32'(un), 32'd0);
    window(hi, un);
    check_eq("play_p2_high", 32'(hi), 32'd159);
    check_eq("play_p2_und", 32'(un), 32'd1);
    window(hi, un);
    check_eq("play_hold_high", 32'(hi), 32'd159);

    // Full FIFO: fifth push refused, order preserved on playback, duty 0 and max boundaries.
    do_reset();
    for (int i = 0; i < 4; i++) push(full_v[i]);
    check_eq("full_level", 32'(level), 32'd4);
    check_eq("full_ready", 32'(s_ready), 32'd0);
    push(full_v[4]);
    check_eq("full_level5", 32'(level), 32'd4);
    en = 1'b1;
    wait_phase(0, "full_start");
    for (int i = 0; i < 4; i++) begin
      window(hi, un);
      check_eq("full_order_high", 32'(hi), 32'(exp_d[i]));
    end

    // Disable mid-period, then resume from the next buffered sample.
    do_reset();
    push(16'h9FFF);
    push(16'h1FFF);
    push(16'hE000);
    en = 1'b1;
    wait_phase(100, "dis_reach");
    en = 1'b0;
    tick();
    check_eq("dis_pwm", 32'(pwm_out), 32'd0);
    check_eq("dis_level", 32'(level), 32'd2);
    repeat (20) tick();
    en = 1'b1;
    wait_phase(0, "resume_start");
    window(hi, un);
    check_eq("resume_high", 32'(hi), 32'd159);
    repeat (37) tick();
    do_reset();

    // Randomized traffic against the model.
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 799) == 0) en = ~en;
      s_valid = ($urandom_range(0, 149) == 0);
      s_data  = 16'($urandom);
      if ($urandom_range(0, 2999) == 0) begin
        do_reset();
        en = 1'b1;
      end else begin
        tick();
      end
      if (c == 10) en = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
